// File: rtl/axi4_lite_write_master_p_if.sv
// Purpose: bundles the core-side request/response port and the AXI4-lite AW/W/B channels of the write master.
// Latency: none, this is wiring only.
// Backpressure: req_ready and the m_*ready/m_bready signals carry the flow control.
// Ports: req_* request in, resp_* status out, m_aw*/m_w*/m_b* AXI4-lite write channels.
// Modports: master is the write-master side; slave is the requester plus AXI-slave side.
interface axi4_lite_write_master_p_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int STRB_W = DATA_W / 8
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;
   logic [STRB_W-1:0] req_strb;

   logic              resp_valid;
   logic [1:0]        resp_bresp;
   logic              resp_timeout;

   logic [ADDR_W-1:0] m_awaddr;
   logic [2:0]        m_awprot;
   logic              m_awvalid;
   logic              m_awready;
   logic [DATA_W-1:0] m_wdata;
   logic [STRB_W-1:0] m_wstrb;
   logic              m_wvalid;
   logic              m_wready;
   logic [1:0]        m_bresp;
   logic              m_bvalid;
   logic              m_bready;

   modport master (
      input  req_valid, req_addr, req_data, req_strb,
      output req_ready,
      output resp_valid, resp_bresp, resp_timeout,
      output m_awaddr, m_awprot, m_awvalid,
      input  m_awready,
      output m_wdata, m_wstrb, m_wvalid,
      input  m_wready,
      input  m_bresp, m_bvalid,
      output m_bready
   );

   modport slave (
      output req_valid, req_addr, req_data, req_strb,
      input  req_ready,
      input  resp_valid, resp_bresp, resp_timeout,
      input  m_awaddr, m_awprot, m_awvalid,
      output m_awready,
      input  m_wdata, m_wstrb, m_wvalid,
      output m_wready,
      output m_bresp, m_bvalid,
      input  m_bready
   );
endinterface

// File: rtl/axi4_lite_write_master_p.sv
// Purpose: single-outstanding AXI4-lite write master; AW and W are issued together, and B is returned as a status pulse.
// Latency: request accepted at N, AW/W at N+1, B at N+2, resp_valid at N+3, ready again at N+4 (minimum).
// Backpressure: req_ready only in IDLE; AW/W/B stalls are bounded by a watchdog that aborts after TIMEOUT cycles.
// Ports: clk, rst_n (synchronous, active-low), busy (state != IDLE), bus (master modport: request, response, AXI channels).
module axi4_lite_write_master_p #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int STRB_W  = DATA_W / 8,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst_n,
   output logic busy,
   axi4_lite_write_master_p_if.master bus
);

   typedef enum logic [1:0] {IDLE, ADDR_DATA, WAIT_B, RESP} state_t;

   localparam logic [CNT_W:0] TMO = (CNT_W + 1)'(TIMEOUT);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              resp_valid_q, resp_valid_d;
   logic [1:0]        resp_bresp_q, resp_bresp_d;
   logic              resp_timeout_q, resp_timeout_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;

   logic              aw_hs, w_hs, b_hs;
   logic [CNT_W:0]    wdog_inc;
   logic [CNT_W-1:0]  wdog_next;
   logic              expire;

   assign aw_hs     = awvalid_q & bus.m_awready;
   assign w_hs      = wvalid_q & bus.m_wready;
   assign b_hs      = bready_q & bus.m_bvalid;

   // The counter holds the number of cycles already spent in ADDR_DATA/WAIT_B.
   // It expires in the cycle whose closing edge would bring it to TIMEOUT, which gives
   // exactly TIMEOUT cycles of waiting. The >= compare still fires if a late AW/W
   // completion carried the count past TIMEOUT into WAIT_B.
   assign wdog_inc  = {1'b0, wdog_q} + (CNT_W + 1)'(1);
   assign wdog_next = (&wdog_q) ? wdog_q : wdog_inc[CNT_W-1:0];
   assign expire    = (TIMEOUT != 0) && (wdog_inc >= TMO);

   always_comb begin
      state_d        = state_q;
      awaddr_d       = awaddr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      awvalid_d      = awvalid_q;
      wvalid_d       = wvalid_q;
      bready_d       = bready_q;
      aw_done_d      = aw_done_q;
      w_done_d       = w_done_q;
      resp_valid_d   = 1'b0;
      resp_bresp_d   = resp_bresp_q;
      resp_timeout_d = resp_timeout_q;
      wdog_d         = wdog_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               awaddr_d  = bus.req_addr;
               wdata_d   = bus.req_data;
               wstrb_d   = bus.req_strb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               wdog_d    = '0;
               state_d   = ADDR_DATA;
            end
         end

         ADDR_DATA: begin
            wdog_d = wdog_next;
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            // Completion in the expiry cycle takes priority over the abort.
            if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
               bready_d = 1'b1;
               state_d  = WAIT_B;
            end else if (expire) begin
               awvalid_d      = 1'b0;
               wvalid_d       = 1'b0;
               bready_d       = 1'b0;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b1;
               resp_bresp_d   = 2'b00;
               state_d        = RESP;
            end
         end

         WAIT_B: begin
            wdog_d = wdog_next;
            if (b_hs) begin
               bready_d       = 1'b0;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b0;
               resp_bresp_d   = bus.m_bresp;
               state_d        = RESP;
            end else if (expire) begin
               bready_d       = 1'b0;
               resp_valid_d   = 1'b1;
               resp_timeout_d = 1'b1;
               resp_bresp_d   = 2'b00;
               state_d        = RESP;
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         awaddr_q       <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         bready_q       <= 1'b0;
         aw_done_q      <= 1'b0;
         w_done_q       <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_bresp_q   <= 2'b00;
         resp_timeout_q <= 1'b0;
         wdog_q         <= '0;
      end else begin
         state_q        <= state_d;
         awaddr_q       <= awaddr_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         awvalid_q      <= awvalid_d;
         wvalid_q       <= wvalid_d;
         bready_q       <= bready_d;
         aw_done_q      <= aw_done_d;
         w_done_q       <= w_done_d;
         resp_valid_q   <= resp_valid_d;
         resp_bresp_q   <= resp_bresp_d;
         resp_timeout_q <= resp_timeout_d;
         wdog_q         <= wdog_d;
      end
   end

   assign bus.req_ready    = (state_q == IDLE);
   assign busy             = (state_q != IDLE);
   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_bresp   = resp_bresp_q;
   assign bus.resp_timeout = resp_timeout_q;
   assign bus.m_awaddr     = awaddr_q;
   assign bus.m_awprot     = 3'b000;
   assign bus.m_awvalid    = awvalid_q;
   assign bus.m_wdata      = wdata_q;
   assign bus.m_wstrb      = wstrb_q;
   assign bus.m_wvalid     = wvalid_q;
   assign bus.m_bready     = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master_p.sv
// Purpose: self-checking bench for axi4_lite_write_master_p (64-bit/TIMEOUT=8 and 32-bit/no-watchdog builds).
// Latency: the expected response cycle for each vector is tabulated relative to request acceptance.
// Backpressure: the slave-side readies and B timing are driven from each vector's delay fields.
module tb_axi4_lite_write_master_p;

   logic clk;
   logic rst_n;
   logic busy64, busy32;

   axi4_lite_write_master_p_if #(.ADDR_W(64), .DATA_W(64)) bus64 ();
   axi4_lite_write_master_p_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();

   axi4_lite_write_master_p #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(8), .CNT_W(8)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .busy(busy64), .bus(bus64)
   );

   axi4_lite_write_master_p #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0), .CNT_W(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .busy(busy32), .bus(bus32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [1:0] bresp;
      logic       timeout;
   } resp_t;
   resp_t sb_q[$];

   // a/w: cycles after acceptance+1 before awready/wready rise (99 = never).
   // b: cycles after both AW and W handshakes before bvalid rises; early_b raises bvalid at once.
   typedef struct {
      logic [63:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
      int          a;
      int          w;
      int          b;
      bit          early_b;
      logic [1:0]  bresp;
      logic [1:0]  exp_bresp;
      bit          exp_to;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input vec_t v);
      bit    aw_d = 1'b0;
      bit    w_d  = 1'b0;
      bit    b_d  = 1'b0;
      bit    got  = 1'b0;
      int    kb   = -1;
      resp_t r;
      check("req_ready_idle", {63'd0, bus64.req_ready}, 64'd1);
      bus64.req_valid = 1'b1;
      bus64.req_addr  = v.addr;
      bus64.req_data  = v.data;
      bus64.req_strb  = v.strb;
      sb_q.push_back('{bresp: v.exp_bresp, timeout: v.exp_to});
      tick();
      // Keep a different request valid while busy: it must be ignored.
      bus64.req_addr = ~v.addr;
      bus64.req_data = ~v.data;
      bus64.req_strb = ~v.strb;
      for (int k = 1; k <= 40 && !got; k++) begin
         bus64.m_awready = (k >= 1 + v.a);
         bus64.m_wready  = (k >= 1 + v.w);
         bus64.m_bvalid  = !b_d && (v.early_b || (kb > 0 && k >= kb + 1 + v.b));
         bus64.m_bresp   = v.bresp;
         #1;
         if (bus64.resp_valid) begin
            got = 1'b1;
            bus64.req_valid = 1'b0;
            check("resp_latency", 64'(k), 64'(v.exp_lat));
            check("resp_valids_low", {61'd0, bus64.m_awvalid, bus64.m_wvalid, bus64.m_bready}, 64'd0);
            if (sb_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_empty: got resp_valid, expected no response");
            end else begin
               r = sb_q.pop_front();
               check("resp_bresp", {62'd0, bus64.resp_bresp}, {62'd0, r.bresp});
               check("resp_timeout", {63'd0, bus64.resp_timeout}, {63'd0, r.timeout});
            end
         end else begin
            check("busy", {63'd0, busy64}, 64'd1);
            check("req_ready_busy", {63'd0, bus64.req_ready}, 64'd0);
            check("awvalid_state", {63'd0, bus64.m_awvalid}, {63'd0, !aw_d});
            check("wvalid_state", {63'd0, bus64.m_wvalid}, {63'd0, !w_d});
            check("bready_state", {63'd0, bus64.m_bready}, {63'd0, aw_d && w_d && !b_d});
            if (bus64.m_awvalid) check("awaddr", bus64.m_awaddr, v.addr);
            if (bus64.m_wvalid) begin
               check("wdata", bus64.m_wdata, v.data);
               check("wstrb", {56'd0, bus64.m_wstrb}, {56'd0, v.strb});
            end
            if (bus64.m_awvalid && bus64.m_awready) aw_d = 1'b1;
            if (bus64.m_wvalid && bus64.m_wready) w_d = 1'b1;
            if (aw_d && w_d && kb < 0) kb = k;
            if (bus64.m_bready && bus64.m_bvalid) b_d = 1'b1;
         end
         tick();
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         bus64.req_valid = 1'b0;
         $display("FAIL resp_missing: got no resp_valid within 40 cycles, expected at %0d", v.exp_lat);
      end
      bus64.m_awready = 1'b0;
      bus64.m_wready  = 1'b0;
      bus64.m_bvalid  = 1'b0;
      #1;
      check("req_ready_after_resp", {63'd0, bus64.req_ready}, 64'd1);
      check("resp_valid_one_cycle", {63'd0, bus64.resp_valid}, 64'd0);
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{64'h0000_0000_8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF,  0,  0,  0, 1'b0, 2'b00, 2'b00, 1'b0,  3};
      vecs[1] = '{64'h0000_0000_8000_0020, 64'h1111_2222_3333_4444, 8'hFF,  0,  3,  0, 1'b0, 2'b00, 2'b00, 1'b0,  6};
      vecs[2] = '{64'h0000_0000_8000_0030, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F,  1,  0,  2, 1'b0, 2'b10, 2'b10, 1'b0,  6};
      vecs[3] = '{64'h0000_0000_8000_0040, 64'h0102_0304_0506_0708, 8'hF0,  2,  2,  0, 1'b0, 2'b01, 2'b01, 1'b0,  5};
      vecs[4] = '{64'h0000_0000_8000_0048, 64'hFFFF_0000_FFFF_0000, 8'h81,  0,  1,  1, 1'b0, 2'b11, 2'b11, 1'b0,  5};
      vecs[5] = '{64'h0000_0000_8000_0050, 64'h7654_3210_FEDC_BA98, 8'h3C,  0,  3,  0, 1'b1, 2'b00, 2'b00, 1'b0,  6};
      vecs[6] = '{64'h0000_0000_8000_0060, 64'h0BAD_F00D_0BAD_F00D, 8'hFF, 99,  0,  0, 1'b0, 2'b11, 2'b00, 1'b1,  9};
      vecs[7] = '{64'h0000_0000_8000_0070, 64'hC0DE_C0DE_C0DE_C0DE, 8'h55,  0,  0, 99, 1'b0, 2'b10, 2'b00, 1'b1,  9};
      vecs[8] = '{64'h0000_0000_8000_0080, 64'h1234_5678_9ABC_DEF0, 8'hAA,  7,  0,  0, 1'b0, 2'b01, 2'b01, 1'b0, 10};
      vecs[9] = '{64'h0000_0000_8000_0090, 64'h0FED_CBA9_8765_4321, 8'h01,  0,  0,  6, 1'b0, 2'b11, 2'b11, 1'b0,  9};

      rst_n = 1'b0;
      bus64.req_valid = 1'b0; bus64.req_addr = '0; bus64.req_data = '0; bus64.req_strb = '0;
      bus64.m_awready = 1'b0; bus64.m_wready = 1'b0; bus64.m_bvalid = 1'b0; bus64.m_bresp = 2'b00;
      bus32.req_valid = 1'b0; bus32.req_addr = '0; bus32.req_data = '0; bus32.req_strb = '0;
      bus32.m_awready = 1'b0; bus32.m_wready = 1'b0; bus32.m_bvalid = 1'b0; bus32.m_bresp = 2'b00;
      repeat (3) tick();

      // Reset state.
      check("rst_req_ready", {63'd0, bus64.req_ready}, 64'd1);
      check("rst_busy", {63'd0, busy64}, 64'd0);
      check("rst_valids", {61'd0, bus64.m_awvalid, bus64.m_wvalid, bus64.m_bready}, 64'd0);
      check("rst_resp", {60'd0, bus64.resp_valid, bus64.resp_bresp, bus64.resp_timeout}, 64'd0);
      check("rst_awaddr", bus64.m_awaddr, 64'd0);
      check("rst_wdata", bus64.m_wdata, 64'd0);
      check("rst_wstrb", {56'd0, bus64.m_wstrb}, 64'd0);
      check("awprot", {61'd0, bus64.m_awprot}, 64'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 10; i++) run_txn(vecs[i]);

      // Reset asserted while waiting for B: aborts with no response.
      bus64.req_valid = 1'b1;
      bus64.req_addr  = 64'h8000_00A0;
      bus64.req_data  = 64'h5555_AAAA_5555_AAAA;
      bus64.req_strb  = 8'hFF;
      bus64.m_awready = 1'b1;
      bus64.m_wready  = 1'b1;
      tick();
      bus64.req_valid = 1'b0;
      tick();
      check("waitb_bready", {63'd0, bus64.m_bready}, 64'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus64.m_awready = 1'b0;
      bus64.m_wready  = 1'b0;
      check("midrst_valids", {61'd0, bus64.m_awvalid, bus64.m_wvalid, bus64.m_bready}, 64'd0);
      check("midrst_req_ready", {63'd0, bus64.req_ready}, 64'd1);
      check("midrst_busy", {63'd0, busy64}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         check("midrst_no_resp", {63'd0, bus64.resp_valid}, 64'd0);
         tick();
      end
      check("midrst_sb_empty", 64'(sb_q.size()), 64'd0);

      // 32-bit build: same-cycle AW/W handshake, 4-bit strobe.
      bus32.req_valid = 1'b1;
      bus32.req_addr  = 32'h1000_0004;
      bus32.req_data  = 32'hCAFE_F00D;
      bus32.req_strb  = 4'hF;
      bus32.m_awready = 1'b1;
      bus32.m_wready  = 1'b1;
      tick();
      bus32.req_valid = 1'b0;
      check("d32_valids_n1", {62'd0, bus32.m_awvalid, bus32.m_wvalid}, 64'd3);
      check("d32_awaddr", {32'd0, bus32.m_awaddr}, 64'h1000_0004);
      check("d32_wdata", {32'd0, bus32.m_wdata}, 64'hCAFE_F00D);
      check("d32_wstrb", {60'd0, bus32.m_wstrb}, 64'hF);
      tick();
      check("d32_after_hs", {61'd0, bus32.m_awvalid, bus32.m_wvalid, bus32.m_bready}, 64'd1);
      bus32.m_bvalid = 1'b1;
      bus32.m_bresp  = 2'b01;
      tick();
      bus32.m_bvalid = 1'b0;
      check("d32_resp", {60'd0, bus32.resp_valid, bus32.resp_bresp, bus32.resp_timeout}, 64'b1010);
      tick();
      check("d32_req_ready", {63'd0, bus32.req_ready}, 64'd1);

      // 32-bit build has the watchdog disabled: a long AW stall never aborts.
      bus32.req_valid = 1'b1;
      bus32.req_addr  = 32'h2000_0008;
      bus32.m_awready = 1'b0;
      tick();
      bus32.req_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         check("d32_stall", {62'd0, bus32.resp_valid, bus32.m_awvalid}, 64'd1);
         tick();
      end
      bus32.m_awready = 1'b1;
      tick();
      check("d32_stall_bready", {63'd0, bus32.m_bready}, 64'd1);
      bus32.m_bvalid = 1'b1;
      bus32.m_bresp  = 2'b10;
      tick();
      bus32.m_bvalid  = 1'b0;
      bus32.m_awready = 1'b0;
      bus32.m_wready  = 1'b0;
      check("d32_stall_resp", {60'd0, bus32.resp_valid, bus32.resp_bresp, bus32.resp_timeout}, 64'b1100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_lite_write_master_p.md
Name: axi4_lite_write_master_p

Overview:
Parametrised single-outstanding AXI4-lite write master for the NPC memory/peripheral path. It accepts one write request (address, data, byte strobe) from the core-side request port and drives the AW and W channels concurrently. It collects the B response and returns status and a timeout flag to the requester. Successor to the fixed 64-bit write master: it adds width parameters, caller-supplied strobes, independent AW/W completion, correct B-channel directions and a watchdog.

Parameters:
ADDR_W, 64, address width in bits
DATA_W, 64, data width in bits; must be 32 or 64
STRB_W, DATA_W/8, write-strobe width (derived; do not override)
TIMEOUT, 255, watchdog cycles in ADDR_DATA/WAIT_B before abort; 0 disables the watchdog
CNT_W, 8, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  clock, all logic on posedge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  write request valid
req_ready  out  1  block can accept a request
req_addr  in  ADDR_W  write byte address
req_data  in  DATA_W  write data
req_strb  in  STRB_W  byte enables
resp_valid  out  1  one-cycle pulse: transaction finished
resp_bresp  out  2  captured BRESP (2'b00 on timeout)
resp_timeout  out  1  qualified by resp_valid; 1 = watchdog abort
busy  out  1  state != IDLE
m_awaddr  out  ADDR_W  AXI write address
m_awprot  out  3  constant 3'b000
m_awvalid  out  1  AXI AW valid
m_awready  in  1  AXI AW ready
m_wdata  out  DATA_W  AXI write data
m_wstrb  out  STRB_W  AXI write strobe
m_wvalid  out  1  AXI W valid
m_wready  in  1  AXI W ready
m_bresp  in  2  AXI write response
m_bvalid  in  1  AXI B valid
m_bready  out  1  AXI B ready

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; m_awvalid=m_wvalid=m_bready=0; resp_valid=0; resp_bresp=0; resp_timeout=0; m_awaddr/m_wdata/m_wstrb=0; watchdog=0. Reset mid-transaction aborts immediately with no resp_valid.
- All outputs registered except req_ready=(state==IDLE) and busy.
- States: IDLE, ADDR_DATA, WAIT_B, RESP.
- IDLE: req_valid&&req_ready registers addr/data/strb and sets m_awvalid=m_wvalid=1 -> ADDR_DATA. Both valids are high in the cycle after acceptance.
- ADDR_DATA: keep aw_done/w_done flags.
  - m_awvalid&&m_awready clears m_awvalid and sets aw_done.
  - m_wvalid&&m_wready clears m_wvalid and sets w_done.
  - The two handshakes complete in either order or in the same cycle.
  - Payload and each valid stay stable until that channel's handshake.
  - When both are done (including the current cycle), set m_bready=1 -> WAIT_B.
- WAIT_B: m_bvalid&&m_bready captures m_bresp into resp_bresp, clears m_bready, sets resp_valid=1, resp_timeout=0 -> RESP.
- RESP: resp_valid high exactly this cycle, then cleared -> IDLE.
- Minimum latency: accept at cycle N; AW/W handshake at N+1; B handshake at N+2; resp_valid at N+3; req_ready again at N+4.
- Watchdog (TIMEOUT>0):
  - Clears on entry to ADDR_DATA; increments each cycle in ADDR_DATA/WAIT_B.
  - On reaching TIMEOUT with no completing handshake that cycle: drop all m_*valid and m_bready, resp_timeout=1, resp_bresp=2'b00 -> RESP.
  - A handshake in the expiry cycle wins over the timeout.
- Any BRESP (OKAY/EXOKAY/SLVERR/DECERR) is passed through unmodified; no retry.
- req_* is ignored while not in IDLE.
- m_bvalid arriving before both AW and W are done is not accepted (m_bready=0).

Test Plan:
- Single write, slave always ready: addr=0x8000_0010, data=0xDEAD_BEEF_0123_4567, strb=0xFF -> AW/W valid at N+1, resp_valid at N+3 with bresp=0, timeout=0.
- AW ready 3 cycles before W ready (W delayed 3): m_awvalid drops after its handshake, m_wvalid holds with stable wdata, bready only after W handshake; resp correct.
- Same-cycle AW/W handshake with wstrb=0x0F and DATA_W=32 build: wstrb=0xF passes, single-cycle ADDR_DATA.
- Slave returns bresp=2'b10: resp_bresp=2'b10, resp_timeout=0; next request accepted in the cycle after RESP.
- TIMEOUT=8, awready held 0: after 8 cycles valids drop, resp_valid=1, resp_timeout=1, resp_bresp=0; next request accepted.
- rst_n=0 asserted while in WAIT_B: next cycle all valids/bready=0, state IDLE, req_ready=1, no resp_valid.
